// File: rtl/ctrl_pkt_initiator_pkg.sv
// Shared constants for the settings control-packet initiator: framing flag positions,
// packet word indices, done_error codes and FSM state encodings.
package ctrl_pkt_initiator_pkg;

    localparam int SOF_BIT = 32;
    localparam int EOF_BIT = 33;

    localparam logic [3:0] HDR_NIBBLE = 4'h1;

    // Command packet word indices (the trailer words are located relative to the length)
    localparam logic [2:0] WIDX_HDR     = 3'd0;
    localparam logic [2:0] WIDX_SID     = 3'd1;
    localparam logic [2:0] WIDX_TIME_HI = 3'd2;
    localparam logic [2:0] LEN_UNTIMED  = 3'd4;
    localparam logic [2:0] LEN_TIMED    = 3'd6;

    // Ack packet word indices; the index saturates one past the readback word
    localparam logic [2:0] ACK_IDX_SID = 3'd1;
    localparam logic [2:0] ACK_IDX_SEQ = 3'd2;
    localparam logic [2:0] ACK_IDX_RB  = 3'd3;
    localparam logic [2:0] ACK_IDX_SAT = 3'd4;

    localparam logic [1:0] ERR_OK        = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd1;
    localparam logic [1:0] ERR_MALFORMED = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic [35:0] frame_word(input logic sof, input logic eof,
                                               input logic [31:0] w);
        return {2'b00, eof, sof, w};
    endfunction

endpackage

// File: rtl/ctrl_ack_parser.sv
// Response-stream parser: tracks the word index of the current packet, rejects packets
// with a foreign SID or stale sequence number, and reports ack completion or malformation.
module ctrl_ack_parser
    import ctrl_pkt_initiator_pkg::*;
#(
    parameter logic [31:0] ACK_SID = 32'd20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en_i,
    input  logic        clear_i,
    input  logic [35:0] resp_data_i,
    input  logic        resp_vld_i,
    input  logic [15:0] seq_i,
    output logic        ack_ok_o,
    output logic        ack_bad_o,
    output logic [31:0] readback_o
);

    logic [2:0]  idx_q, idx_d;
    logic        in_pkt_q, in_pkt_d;
    logic        drop_q, drop_d;
    logic [31:0] rb_q;

    logic        word_vld, sof, eof, active, reject, good;
    logic [2:0]  cur_idx;
    logic [31:0] w;

    // Words with reserved flag bits set are not part of this stream
    assign word_vld = en_i & resp_vld_i & (resp_data_i[35:34] == 2'b00);
    assign sof      = resp_data_i[SOF_BIT];
    assign eof      = resp_data_i[EOF_BIT];
    assign w        = resp_data_i[31:0];

    assign cur_idx = sof ? WIDX_HDR : idx_q;
    assign active  = sof | (in_pkt_q & ~drop_q);
    assign reject  = ((cur_idx == ACK_IDX_SID) && (w != ACK_SID)) ||
                     ((cur_idx == ACK_IDX_SEQ) && (w[31:16] != seq_i));
    assign good    = word_vld & active & ~reject;

    assign ack_ok_o   = good & eof & (cur_idx >= ACK_IDX_RB);
    assign ack_bad_o  = good & eof & (cur_idx < ACK_IDX_RB);
    assign readback_o = (cur_idx == ACK_IDX_RB) ? w : rb_q;

    always_comb begin
        idx_d    = idx_q;
        in_pkt_d = in_pkt_q;
        drop_d   = drop_q;
        if (clear_i) begin
            idx_d    = '0;
            in_pkt_d = 1'b0;
            drop_d   = 1'b0;
        end else if (word_vld) begin
            if (eof) begin
                idx_d    = '0;
                in_pkt_d = 1'b0;
                drop_d   = 1'b0;
            end else if (active) begin
                in_pkt_d = 1'b1;
                drop_d   = reject;
                idx_d    = (cur_idx == ACK_IDX_SAT) ? cur_idx : cur_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q    <= '0;
            in_pkt_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            in_pkt_q <= in_pkt_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (good && (cur_idx == ACK_IDX_RB)) begin
            rb_q <= w;
        end
    end

endmodule

// File: rtl/ctrl_pkt_initiator.sv
// Host-side settings control-packet initiator: builds one command packet per request,
// then waits (bounded) for the matching ack and reports the result on a done pulse.
module ctrl_pkt_initiator
    import ctrl_pkt_initiator_pkg::*;
#(
    parameter logic [31:0] CMD_SID        = 32'd0,
    parameter logic [31:0] ACK_SID        = 32'd20,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_rb_sel,
    input  logic        cmd_timed,
    input  logic [63:0] cmd_time,
    output logic [35:0] ctrl_data,
    output logic        ctrl_src_rdy,
    input  logic        ctrl_dst_rdy,
    input  logic [35:0] resp_data,
    input  logic        resp_src_rdy,
    output logic        resp_dst_rdy,
    output logic        done_valid,
    output logic [15:0] done_seq,
    output logic [31:0] done_readback,
    output logic [1:0]  done_error
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic        init_q;
    logic [2:0]  widx_q, widx_d;
    logic [15:0] seq_q, seq_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdbk_q, rdbk_d;

    logic [7:0]  addr_q;
    logic [31:0] data_q;
    logic [3:0]  rbsel_q;
    logic        timed_q;
    logic [63:0] time_q;

    logic        cmd_acc, word_acc, pkt_end;
    logic [2:0]  len, last_idx;
    logic [31:0] word;
    logic        ack_ok, ack_bad;
    logic [31:0] ack_rb;

    assign cmd_ready    = init_q && (state_q == ST_IDLE);
    assign cmd_acc      = cmd_valid && cmd_ready;
    assign ctrl_src_rdy = (state_q == ST_SEND);
    assign word_acc     = ctrl_src_rdy && ctrl_dst_rdy;
    assign len          = timed_q ? LEN_TIMED : LEN_UNTIMED;
    assign last_idx     = len - 3'd1;
    assign pkt_end      = word_acc && (widx_q == last_idx);

    // Trailer words sit at fixed offsets from the end so timed packets just shift them
    always_comb begin
        word = 32'h0;
        if (widx_q == WIDX_HDR) begin
            word = {HDR_NIBBLE, 7'b0, timed_q, seq_q[3:0], 13'b0, len};
        end else if (widx_q == WIDX_SID) begin
            word = CMD_SID;
        end else if (widx_q == last_idx) begin
            word = data_q;
        end else if (widx_q == last_idx - 3'd1) begin
            word = {seq_q, 4'h0, rbsel_q, addr_q};
        end else if (widx_q == WIDX_TIME_HI) begin
            word = time_q[63:32];
        end else begin
            word = time_q[31:0];
        end
    end

    assign ctrl_data = ctrl_src_rdy ?
                       frame_word(widx_q == WIDX_HDR, widx_q == last_idx, word) : '0;

    ctrl_ack_parser #(
        .ACK_SID (ACK_SID)
    ) u_parser (
        .clk         (clk),
        .reset_n     (reset_n),
        .en_i        (state_q == ST_WAIT),
        .clear_i     (pkt_end),
        .resp_data_i (resp_data),
        .resp_vld_i  (resp_src_rdy),
        .seq_i       (seq_q),
        .ack_ok_o    (ack_ok),
        .ack_bad_o   (ack_bad),
        .readback_o  (ack_rb)
    );

    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdbk_d  = rdbk_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    state_d = ST_SEND;
                    widx_d  = WIDX_HDR;
                end
            end
            ST_SEND: begin
                if (pkt_end) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (word_acc) begin
                    widx_d = widx_q + 3'd1;
                end
            end
            ST_WAIT: begin
                if (cnt_q != TMO_LAST) begin
                    cnt_d = cnt_q + 32'd1;
                end
                // An ack landing on the expiry cycle still counts as success
                if (ack_ok) begin
                    state_d = ST_DONE;
                    err_d   = ERR_OK;
                    rdbk_d  = ack_rb;
                end else if (ack_bad) begin
                    state_d = ST_DONE;
                    err_d   = ERR_MALFORMED;
                    rdbk_d  = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_DONE;
                    err_d   = ERR_TIMEOUT;
                    rdbk_d  = '0;
                end
            end
            ST_DONE: begin
                seq_d   = seq_q + 16'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            init_q  <= 1'b0;
            widx_q  <= '0;
            seq_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            widx_q  <= widx_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        err_q  <= err_d;
        rdbk_q <= rdbk_d;
        if (cmd_acc) begin
            addr_q  <= cmd_addr;
            data_q  <= cmd_data;
            rbsel_q <= cmd_rb_sel;
            timed_q <= cmd_timed;
            time_q  <= cmd_time;
        end
    end

    assign resp_dst_rdy  = (state_q != ST_DONE);
    assign done_valid    = (state_q == ST_DONE);
    assign done_seq      = done_valid ? seq_q  : '0;
    assign done_readback = done_valid ? rdbk_q : '0;
    assign done_error    = done_valid ? err_q  : '0;

endmodule

// File: tb/tb_ctrl_pkt_initiator.sv
// Directed bench for ctrl_pkt_initiator: packet format, backpressure, ack filtering,
// timeout, sequence wrap and mid-packet reset.
module tb_ctrl_pkt_initiator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_rb_sel;
    logic        cmd_timed;
    logic [63:0] cmd_time;
    logic [35:0] ctrl_data;
    logic        ctrl_src_rdy, ctrl_dst_rdy;
    logic [35:0] resp_data;
    logic        resp_src_rdy, resp_dst_rdy;
    logic        done_valid;
    logic [15:0] done_seq;
    logic [31:0] done_readback;
    logic [1:0]  done_error;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_seq;

    logic [35:0] cap [8];
    int          cap_n, cap_lat;
    bit          cap_stable, cap_ok;
    logic [35:0] pkt [8];
    int          rd_n;
    logic [15:0] rd_seq;
    logic [31:0] rd_rb;
    logic [1:0]  rd_err;

    always #5 clk = ~clk;

    ctrl_pkt_initiator #(
        .CMD_SID        (32'd0),
        .ACK_SID        (32'd20),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .cmd_rb_sel    (cmd_rb_sel),
        .cmd_timed     (cmd_timed),
        .cmd_time      (cmd_time),
        .ctrl_data     (ctrl_data),
        .ctrl_src_rdy  (ctrl_src_rdy),
        .ctrl_dst_rdy  (ctrl_dst_rdy),
        .resp_data     (resp_data),
        .resp_src_rdy  (resp_src_rdy),
        .resp_dst_rdy  (resp_dst_rdy),
        .done_valid    (done_valid),
        .done_seq      (done_seq),
        .done_readback (done_readback),
        .done_error    (done_error)
    );

    // Issue one command and collect the emitted packet words
    task automatic send_cmd(input logic [7:0] a, input logic [31:0] d, input logic [3:0] rb,
                            input logic timed, input logic [63:0] tm, input bit toggle);
        int guard;
        int cyc;
        bit stalled;
        logic [35:0] held;
        cap_n = 0; cap_lat = -1; cap_stable = 1'b1; cap_ok = 1'b0;
        cmd_addr = a; cmd_data = d; cmd_rb_sel = rb; cmd_timed = timed; cmd_time = tm;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        stalled = 1'b0; held = '0; cyc = 0;
        while (guard < 100) begin
            ctrl_dst_rdy = toggle ? cyc[0] : 1'b1;
            if (ctrl_src_rdy && cap_lat < 0) cap_lat = cyc;
            if (stalled && ctrl_data !== held) cap_stable = 1'b0;
            stalled = ctrl_src_rdy && !ctrl_dst_rdy;
            held = ctrl_data;
            if (ctrl_src_rdy && ctrl_dst_rdy) begin
                if (cap_n < 8) cap[cap_n] = ctrl_data;
                cap_n++;
                if (ctrl_data[33]) begin
                    @(posedge clk); #1;
                    ctrl_dst_rdy = 1'b1;
                    cap_ok = 1'b1;
                    break;
                end
            end
            @(posedge clk); #1;
            cyc++; guard++;
        end
        ctrl_dst_rdy = 1'b1;
    endtask

    task automatic build_ack(input logic [31:0] sid, input logic [15:0] seq,
                             input logic [31:0] rb);
        pkt[0] = {4'b0001, 32'h0000_0004};
        pkt[1] = {4'b0000, sid};
        pkt[2] = {4'b0000, seq, 16'h0000};
        pkt[3] = {4'b0010, rb};
    endtask

    // Stream n words of pkt and record any done pulses, including one cycle after
    task automatic send_resp(input int n);
        rd_n = 0; rd_seq = '0; rd_rb = '0; rd_err = '0;
        for (int i = 0; i < n; i++) begin
            resp_data = pkt[i];
            resp_src_rdy = 1'b1;
            @(posedge clk); #1;
            if (done_valid) begin
                rd_n++; rd_seq = done_seq; rd_rb = done_readback; rd_err = done_error;
            end
        end
        resp_src_rdy = 1'b0;
        resp_data = '0;
        @(posedge clk); #1;
        if (done_valid) begin
            rd_n++; rd_seq = done_seq; rd_rb = done_readback; rd_err = done_error;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
        n_cmp++; if (ctrl_src_rdy !== 1'b0) begin n_err++; $display("FAIL rst_src_rdy: got %b want 0", ctrl_src_rdy); end
        n_cmp++; if (done_valid !== 1'b0) begin n_err++; $display("FAIL rst_done_valid: got %b want 0", done_valid); end
        n_cmp++; if (done_seq !== 16'h0) begin n_err++; $display("FAIL rst_done_seq: got %h want 0", done_seq); end
        n_cmp++; if (done_readback !== 32'h0) begin n_err++; $display("FAIL rst_done_rb: got %h want 0", done_readback); end
        n_cmp++; if (done_error !== 2'd0) begin n_err++; $display("FAIL rst_done_err: got %0d want 0", done_error); end
        n_cmp++; if (resp_dst_rdy !== 1'b1) begin n_err++; $display("FAIL rst_resp_dst_rdy: got %b want 1", resp_dst_rdy); end
        reset_n = 1'b1;
        #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_first_cycle: got %b want 0", cmd_ready); end
        @(posedge clk); #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b want 1", cmd_ready); end
        exp_seq = 16'h0;
    endtask

    task automatic test_untimed();
        send_cmd(8'h20, 32'hDEADBEEF, 4'h1, 1'b0, 64'h0, 1'b0);
        n_cmp++; if (cap_ok !== 1'b1 || cap_n !== 4) begin n_err++; $display("FAIL untimed_len: got %0d words want 4", cap_n); end
        n_cmp++; if (cap_lat !== 0) begin n_err++; $display("FAIL untimed_latency: got %0d want 0", cap_lat); end
        n_cmp++; if (cap[0] !== 36'h1_1000_0004) begin n_err++; $display("FAIL untimed_w0: got %h want 110000004", cap[0]); end
        n_cmp++; if (cap[1] !== 36'h0_0000_0000) begin n_err++; $display("FAIL untimed_w1: got %h want 000000000", cap[1]); end
        n_cmp++; if (cap[2] !== 36'h0_0000_0120) begin n_err++; $display("FAIL untimed_w2: got %h want 000000120", cap[2]); end
        n_cmp++; if (cap[3] !== 36'h2_DEAD_BEEF) begin n_err++; $display("FAIL untimed_w3: got %h want 2deadbeef", cap[3]); end
        build_ack(32'd20, 16'h0, 32'h1234_5678);
        send_resp(4);
        n_cmp++; if (rd_n !== 1) begin n_err++; $display("FAIL untimed_done_cnt: got %0d want 1", rd_n); end
        n_cmp++; if (rd_seq !== 16'h0) begin n_err++; $display("FAIL untimed_done_seq: got %h want 0", rd_seq); end
        n_cmp++; if (rd_rb !== 32'h1234_5678) begin n_err++; $display("FAIL untimed_done_rb: got %h want 12345678", rd_rb); end
        n_cmp++; if (rd_err !== 2'd0) begin n_err++; $display("FAIL untimed_done_err: got %0d want 0", rd_err); end
        exp_seq = 16'd1;
    endtask

    task automatic test_timed();
        send_cmd(8'h05, 32'h0000_00AA, 4'h2, 1'b1, 64'h1_0000_0002, 1'b0);
        n_cmp++; if (cap_n !== 6) begin n_err++; $display("FAIL timed_len: got %0d want 6", cap_n); end
        n_cmp++; if (cap[0] !== 36'h1_1011_0006) begin n_err++; $display("FAIL timed_w0: got %h want 110110006", cap[0]); end
        n_cmp++; if (cap[2] !== 36'h0_0000_0001) begin n_err++; $display("FAIL timed_w2: got %h want 000000001", cap[2]); end
        n_cmp++; if (cap[3] !== 36'h0_0000_0002) begin n_err++; $display("FAIL timed_w3: got %h want 000000002", cap[3]); end
        n_cmp++; if (cap[4] !== 36'h0_0001_0205) begin n_err++; $display("FAIL timed_w4: got %h want 000010205", cap[4]); end
        n_cmp++; if (cap[5] !== 36'h2_0000_00AA) begin n_err++; $display("FAIL timed_w5: got %h want 2000000aa", cap[5]); end
        build_ack(32'd20, 16'd1, 32'h000B_0001);
        send_resp(4);
        n_cmp++; if (rd_n !== 1 || rd_seq !== 16'd1) begin n_err++; $display("FAIL timed_done: got cnt %0d seq %h want 1/0001", rd_n, rd_seq); end
        n_cmp++; if (rd_rb !== 32'h000B_0001) begin n_err++; $display("FAIL timed_readback: got %h want 000b0001", rd_rb); end
        exp_seq = 16'd2;
    endtask

    task automatic test_backpressure();
        send_cmd(8'h7F, 32'hCAFE_F00D, 4'hF, 1'b0, 64'h0, 1'b1);
        n_cmp++; if (cap_n !== 4) begin n_err++; $display("FAIL bp_len: got %0d want 4", cap_n); end
        n_cmp++; if (cap_stable !== 1'b1) begin n_err++; $display("FAIL bp_stable: got %b want 1", cap_stable); end
        n_cmp++; if (cap[0] !== 36'h1_1002_0004) begin n_err++; $display("FAIL bp_w0: got %h want 110020004", cap[0]); end
        n_cmp++; if (cap[1] !== 36'h0_0000_0000) begin n_err++; $display("FAIL bp_w1: got %h want 000000000", cap[1]); end
        n_cmp++; if (cap[2] !== 36'h0_0002_0F7F) begin n_err++; $display("FAIL bp_w2: got %h want 000020f7f", cap[2]); end
        n_cmp++; if (cap[3] !== 36'h2_CAFE_F00D) begin n_err++; $display("FAIL bp_w3: got %h want 2cafef00d", cap[3]); end
        build_ack(32'd20, 16'd2, 32'hA5A5_0002);
        send_resp(4);
        n_cmp++; if (rd_n !== 1 || rd_rb !== 32'hA5A5_0002) begin n_err++; $display("FAIL bp_done: got cnt %0d rb %h want 1/a5a50002", rd_n, rd_rb); end
        exp_seq = 16'd3;
    endtask

    task automatic test_timeout();
        int c;
        send_cmd(8'h01, 32'h1, 4'h0, 1'b0, 64'h0, 1'b0);
        c = 0;
        while (!done_valid && c < 300) begin
            @(posedge clk); #1; c++;
        end
        n_cmp++; if (c !== 100) begin n_err++; $display("FAIL tmo_cycles: got %0d want 100", c); end
        n_cmp++; if (done_error !== 2'd1) begin n_err++; $display("FAIL tmo_error: got %0d want 1", done_error); end
        n_cmp++; if (done_readback !== 32'h0) begin n_err++; $display("FAIL tmo_readback: got %h want 0", done_readback); end
        n_cmp++; if (done_seq !== 16'd3) begin n_err++; $display("FAIL tmo_seq: got %h want 0003", done_seq); end
        @(posedge clk); #1;
        exp_seq = 16'd4;
        // late ack for the timed-out command must be ignored
        send_cmd(8'h02, 32'h2, 4'h0, 1'b0, 64'h0, 1'b0);
        build_ack(32'd20, 16'd3, 32'h0000_0BAD);
        send_resp(4);
        n_cmp++; if (rd_n !== 0) begin n_err++; $display("FAIL tmo_stale_dropped: got %0d done want 0", rd_n); end
        build_ack(32'd20, 16'd4, 32'h0000_600D);
        send_resp(4);
        n_cmp++; if (rd_n !== 1 || rd_seq !== 16'd4 || rd_rb !== 32'h600D) begin n_err++; $display("FAIL tmo_next_ack: got cnt %0d seq %h rb %h want 1/0004/0000600d", rd_n, rd_seq, rd_rb); end
        exp_seq = 16'd5;
        // ack EOF lands exactly on the expiry cycle
        send_cmd(8'h03, 32'h3, 4'h0, 1'b0, 64'h0, 1'b0);
        repeat (96) @(posedge clk);
        #1;
        build_ack(32'd20, 16'd5, 32'h0000_1ACE);
        send_resp(4);
        n_cmp++; if (rd_n !== 1 || rd_err !== 2'd0 || rd_rb !== 32'h1ACE) begin n_err++; $display("FAIL tmo_ack_race: got cnt %0d err %0d rb %h want 1/0/00001ace", rd_n, rd_err, rd_rb); end
        exp_seq = 16'd6;
    endtask

    task automatic test_filter();
        send_cmd(8'h10, 32'h10, 4'h3, 1'b0, 64'h0, 1'b0);
        build_ack(32'd7, 16'd6, 32'h1111_1111);
        send_resp(4);
        n_cmp++; if (rd_n !== 0) begin n_err++; $display("FAIL filt_foreign_sid: got %0d done want 0", rd_n); end
        build_ack(32'd20, 16'd9, 32'h2222_2222);
        send_resp(4);
        n_cmp++; if (rd_n !== 0) begin n_err++; $display("FAIL filt_seq_mismatch: got %0d done want 0", rd_n); end
        build_ack(32'd20, 16'd6, 32'hF00D_0006);
        send_resp(4);
        n_cmp++; if (rd_n !== 1 || rd_rb !== 32'hF00D_0006 || rd_err !== 2'd0) begin n_err++; $display("FAIL filt_valid_ack: got cnt %0d rb %h err %0d want 1/f00d0006/0", rd_n, rd_rb, rd_err); end
        exp_seq = 16'd7;
        send_cmd(8'h11, 32'h11, 4'h0, 1'b0, 64'h0, 1'b0);
        build_ack(32'd20, 16'd7, 32'h0);
        pkt[2][33] = 1'b1;
        send_resp(3);
        n_cmp++; if (rd_n !== 1 || rd_err !== 2'd2) begin n_err++; $display("FAIL filt_malformed: got cnt %0d err %0d want 1/2", rd_n, rd_err); end
        n_cmp++; if (rd_rb !== 32'h0 || rd_seq !== 16'd7) begin n_err++; $display("FAIL filt_malformed_fields: got rb %h seq %h want 0/0007", rd_rb, rd_seq); end
        exp_seq = 16'd8;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 260; k++) begin
            send_cmd(k[7:0], 32'(k), k[3:0], 1'b0, 64'h0, 1'b0);
            n_cmp++; if (cap[0][19:16] !== exp_seq[3:0]) begin n_err++; $display("FAIL b2b_w0_seq cmd %0d: got %h want %h", k, cap[0][19:16], exp_seq[3:0]); end
            build_ack(32'd20, exp_seq, 32'(k));
            send_resp(4);
            n_cmp++; if (rd_n !== 1 || rd_seq !== exp_seq || rd_rb !== 32'(k)) begin n_err++; $display("FAIL b2b_done cmd %0d: got cnt %0d seq %h rb %h want 1/%h/%h", k, rd_n, rd_seq, rd_rb, exp_seq, 32'(k)); end
            exp_seq = exp_seq + 16'd1;
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        cmd_addr = 8'h44; cmd_data = 32'h4444; cmd_rb_sel = 4'h4; cmd_timed = 1'b0; cmd_time = '0;
        cmd_valid = 1'b1;
        ctrl_dst_rdy = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_cmp++; if (ctrl_src_rdy !== 1'b1) begin n_err++; $display("FAIL midrst_sending: got %b want 1", ctrl_src_rdy); end
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (ctrl_src_rdy !== 1'b0) begin n_err++; $display("FAIL midrst_src_rdy: got %b want 0", ctrl_src_rdy); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL midrst_cmd_ready: got %b want 0", cmd_ready); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses want 0", seen); end
        exp_seq = 16'h0;
        send_cmd(8'h20, 32'hDEADBEEF, 4'h1, 1'b0, 64'h0, 1'b0);
        n_cmp++; if (cap[0] !== 36'h1_1000_0004) begin n_err++; $display("FAIL midrst_seq_restart: got %h want 110000004", cap[0]); end
        build_ack(32'd20, 16'h0, 32'h0000_0055);
        send_resp(4);
        n_cmp++; if (rd_n !== 1 || rd_seq !== 16'h0) begin n_err++; $display("FAIL midrst_ack: got cnt %0d seq %h want 1/0000", rd_n, rd_seq); end
    endtask

    initial begin
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_rb_sel = '0;
        cmd_timed = 1'b0; cmd_time = '0;
        ctrl_dst_rdy = 1'b1;
        resp_data = '0; resp_src_rdy = 1'b0;
        exp_seq = '0;
        test_reset();
        test_untimed();
        test_timed();
        test_backpressure();
        test_timeout();
        test_filter();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
